// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
//   div_state_t  : FSM state encoding (IDLE, CALC, FIX, DONE)
//   DIV_LATENCY  : cycles from the second-operand capture edge to the
//                  result pulse, for the default 32-bit width
//   div_latency(): the same figure for an arbitrary width
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DIV_LATENCY   = DEFAULT_WIDTH + 2;

   function automatic int div_latency(input int width);
      return width + 2;
   endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on magnitudes.
//   rem_in  : partial remainder (always < dmag, so WIDTH bits suffice)
//   quo_in  : remaining dividend bits (MSB first) / quotient bits so far
//   dmag    : divisor magnitude
//   rem_out : next partial remainder
//   quo_out : quo_in shifted left with the new quotient bit in the LSB
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] dmag,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      shifted = {rem_in, quo_in[WIDTH-1]};
      fits    = (shifted >= {1'b0, dmag});
      // When the subtraction succeeds the true difference is below dmag,
      // so the low WIDTH bits of a WIDTH-bit subtract are exact.
      diff    = shifted[WIDTH-1:0] - dmag;
      if (fits) begin
         rem_out = diff;
         quo_out = {quo_in[WIDTH-2:0], 1'b1};
      end else begin
         rem_out = shifted[WIDTH-1:0];
         quo_out = {quo_in[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring radix-2 divider with two valid/ready operand channels
// and a single-cycle result pulse (no backpressure).
//   clk, reset             : clock, synchronous active-high reset
//   s_axis_dividend_*      : dividend channel (tvalid/tready/tdata)
//   s_axis_divisor_*       : divisor channel (tvalid/tready/tdata)
//   m_axis_dout_tvalid     : one-cycle result pulse
//   m_axis_dout_tdata      : {remainder, quotient}, held after the pulse
// Handshake: an operand transfers on a rising edge where tvalid && tready.
// tready is high only in IDLE for a channel not yet captured and never
// during reset; tready does not depend on tvalid.
// The FSM state is visible as the internal signal 'state'.
module seq_divider
   import divider_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               s_axis_dividend_tvalid,
   output logic               s_axis_dividend_tready,
   input  logic [WIDTH-1:0]   s_axis_dividend_tdata,
   input  logic               s_axis_divisor_tvalid,
   output logic               s_axis_divisor_tready,
   input  logic [WIDTH-1:0]   s_axis_divisor_tdata,
   output logic               m_axis_dout_tvalid,
   output logic [2*WIDTH-1:0] m_axis_dout_tdata
);

   localparam int CW = $clog2(WIDTH);

   div_state_t       state;
   div_state_t       state_next;
   logic             have_a;
   logic             have_b;
   logic             take_a;
   logic             take_b;
   logic             both_in;
   logic             neg_a;
   logic             neg_b;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dmag;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] rem_fix;
   logic [WIDTH-1:0] quo_fix;
   logic [CW-1:0]    cnt;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return (SIGNED && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   assign s_axis_dividend_tready = !reset && (state == IDLE) && !have_a;
   assign s_axis_divisor_tready  = !reset && (state == IDLE) && !have_b;
   assign take_a  = s_axis_dividend_tvalid && s_axis_dividend_tready;
   assign take_b  = s_axis_divisor_tvalid && s_axis_divisor_tready;
   assign both_in = (have_a || take_a) && (have_b || take_b);

   // Reset aborts a divide even if it lands in the DONE cycle.
   assign m_axis_dout_tvalid = (state == DONE) && !reset;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem),
      .quo_in  (quo),
      .dmag    (dmag),
      .rem_out (rem_step),
      .quo_out (quo_step)
   );

   // Quotient is negative when operand signs differ; the remainder takes
   // the dividend's sign (truncating division).
   assign quo_fix = (neg_a ^ neg_b) ? (~quo + 1'b1) : quo;
   assign rem_fix = neg_a ? (~rem + 1'b1) : rem;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (both_in) state_next = CALC;
         CALC:    if (cnt == '0) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         have_a            <= 1'b0;
         have_b            <= 1'b0;
         neg_a             <= 1'b0;
         neg_b             <= 1'b0;
         rem               <= '0;
         quo               <= '0;
         dmag              <= '0;
         cnt               <= '0;
         m_axis_dout_tdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               rem <= '0;
               cnt <= CW'(WIDTH - 1);
               if (take_a) begin
                  have_a <= 1'b1;
                  quo    <= mag(s_axis_dividend_tdata);
                  neg_a  <= SIGNED && s_axis_dividend_tdata[WIDTH-1];
               end
               if (take_b) begin
                  have_b <= 1'b1;
                  dmag   <= mag(s_axis_divisor_tdata);
                  neg_b  <= SIGNED && s_axis_divisor_tdata[WIDTH-1];
               end
            end
            CALC: begin
               rem <= rem_step;
               quo <= quo_step;
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               m_axis_dout_tdata <= {rem_fix, quo_fix};
            end
            DONE: begin
               have_a <= 1'b0;
               have_b <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: one signed (index 0) and one unsigned (index 1)
// instance. Drivers push {expected data, expected pulse cycle} when an
// operand pair is captured; a monitor pops and compares on every pulse.
module tb_seq_divider;
   import divider_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [1:0]        va = '0;
   logic [1:0]        vb = '0;
   logic [1:0]        ra;
   logic [1:0]        rb;
   logic [1:0]        ov;
   logic [1:0][31:0]  da = '0;
   logic [1:0][31:0]  db = '0;
   logic [1:0][63:0]  od;

   int checks = 0;
   int passes = 0;
   int cyc = 0;

   logic [63:0] exp_q0[$];
   logic [63:0] exp_q1[$];
   int          exp_c0[$];
   int          exp_c1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_s (
      .clk(clk), .reset(reset),
      .s_axis_dividend_tvalid(va[0]), .s_axis_dividend_tready(ra[0]),
      .s_axis_dividend_tdata(da[0]),
      .s_axis_divisor_tvalid(vb[0]), .s_axis_divisor_tready(rb[0]),
      .s_axis_divisor_tdata(db[0]),
      .m_axis_dout_tvalid(ov[0]), .m_axis_dout_tdata(od[0])
   );

   seq_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_u (
      .clk(clk), .reset(reset),
      .s_axis_dividend_tvalid(va[1]), .s_axis_dividend_tready(ra[1]),
      .s_axis_dividend_tdata(da[1]),
      .s_axis_divisor_tvalid(vb[1]), .s_axis_divisor_tready(rb[1]),
      .s_axis_divisor_tdata(db[1]),
      .m_axis_dout_tvalid(ov[1]), .m_axis_dout_tdata(od[1])
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic fail(input string name);
      checks++;
      $display("FAIL %s: event did not occur (cycle %0d)", name, cyc);
   endtask

   // Reference: truncating division; x/0 gives magnitude quotient all ones
   // and magnitude remainder |x|, with the usual sign rules applied.
   function automatic logic [63:0] model(input int u, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q;
      logic [31:0] r;
      longint      sa;
      longint      sb;
      if (u == 1) begin
         if (b == 0) begin q = '1; r = a; end
         else begin q = a / b; r = a % b; end
      end else if (b == 0) begin
         q = a[31] ? 32'd1 : 32'hFFFF_FFFF;
         r = a;
      end else begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         q  = 32'(sa / sb);
         r  = 32'(sa % sb);
      end
      return {r, q};
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic push_exp(input int u, input logic [63:0] d, input int c);
      if (u == 0) begin exp_q0.push_back(d); exp_c0.push_back(c); end
      else        begin exp_q1.push_back(d); exp_c1.push_back(c); end
   endtask

   // Monitor: every result pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      for (int u = 0; u < 2; u++) begin
         if (ov[u]) begin
            if ((u == 0 && exp_q0.size() == 0) || (u == 1 && exp_q1.size() == 0)) begin
               checks++;
               $display("FAIL unexpected_tvalid: dut %0d pulsed with %h, none expected (cycle %0d)",
                        u, od[u], cyc);
            end else if (u == 0) begin
               chk("dout_tdata_s", od[0], exp_q0.pop_front());
               chk("dout_cycle_s", 64'(cyc), 64'(exp_c0.pop_front()));
            end else begin
               chk("dout_tdata_u", od[1], exp_q1.pop_front());
               chk("dout_cycle_u", 64'(cyc), 64'(exp_c1.pop_front()));
            end
         end
      end
   end

   // Called and returning #1 after a rising edge. Offers dividend after
   // a_dly cycles and divisor after b_dly cycles, then while busy optionally
   // offers junk operands that must not be taken.
   task automatic do_div(input int u, input logic [31:0] a, input logic [31:0] b,
                         input int a_dly, input int b_dly, input bit junk,
                         input logic [63:0] exp);
      bit got_a = 0;
      bit got_b = 0;
      bit seen  = 0;
      int k     = 0;
      while (!(got_a && got_b) && k < 200) begin
         va[u] = !got_a && (k >= a_dly);
         vb[u] = !got_b && (k >= b_dly);
         da[u] = a;
         db[u] = b;
         @(negedge clk);
         if (got_a) chk("dividend_tready_after_capture", 64'(ra[u]), 64'd0);
         if (got_b) chk("divisor_tready_after_capture", 64'(rb[u]), 64'd0);
         if (va[u] && ra[u]) got_a = 1;
         if (vb[u] && rb[u]) got_b = 1;
         if (got_a && got_b) push_exp(u, exp, cyc + DIV_LATENCY);
         @(posedge clk); #1;
         k++;
      end
      if (!(got_a && got_b)) fail("operand_capture");
      k = 0;
      while (!seen && k < 100) begin
         va[u] = junk;
         vb[u] = junk;
         da[u] = 32'($urandom);
         db[u] = 32'($urandom);
         @(negedge clk);
         chk("busy_dividend_tready", 64'(ra[u]), 64'd0);
         chk("busy_divisor_tready", 64'(rb[u]), 64'd0);
         if (ov[u]) seen = 1;
         @(posedge clk); #1;
         k++;
      end
      if (!seen) fail("dout_tvalid_wait");
      va[u] = 0;
      vb[u] = 0;
      @(negedge clk);
      chk("dividend_tready_after_done", 64'(ra[u]), 64'd1);
      chk("divisor_tready_after_done", 64'(rb[u]), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] b;
      int          u;

      // Reset state
      @(posedge clk); #1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_tvalid", 64'(ov[i]), 64'd0);
         chk("reset_tdata", od[i], 64'd0);
         chk("reset_dividend_tready", 64'(ra[i]), 64'd0);
         chk("reset_divisor_tready", 64'(rb[i]), 64'd0);
      end
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("idle_dividend_tready", 64'(ra[0]), 64'd1);
      chk("idle_divisor_tready", 64'(rb[1]), 64'd1);
      @(posedge clk); #1;

      // Directed cases
      do_div(0, 32'd7, 32'd2, 0, 0, 0, 64'h00000001_00000003);
      do_div(0, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 64'hFFFFFFFF_FFFFFFFD);
      do_div(1, 32'hFFFF_FFFF, 32'h10, 0, 0, 0, 64'h0000000F_0FFFFFFF);
      do_div(1, 32'd5, 32'd0, 0, 0, 0, 64'h00000005_FFFFFFFF);
      do_div(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 64'h00000000_80000000);
      do_div(0, 32'hFFFF_FFF9, 32'd0, 0, 0, 0, 64'hFFFFFFF9_00000001);
      // Staggered: divisor first, dividend five cycles later, junk while busy
      do_div(0, 32'd1000, 32'hFFFF_FFFD, 5, 0, 1, 64'h00000001_FFFFFEB3);
      do_div(1, 32'd1000, 32'd3, 0, 5, 1, 64'h00000001_0000014D);

      // Reset mid-divide: no result may ever appear for it
      va[0] = 1; vb[0] = 1; da[0] = 32'd1234; db[0] = 32'd5;
      @(posedge clk); #1;
      va[0] = 0; vb[0] = 0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1;
      @(negedge clk);
      chk("reset_mid_dividend_tready", 64'(ra[0]), 64'd0);
      chk("reset_mid_divisor_tready", 64'(rb[0]), 64'd0);
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
      chk("post_reset_dividend_tready", 64'(ra[0]), 64'd1);
      chk("post_reset_divisor_tready", 64'(rb[0]), 64'd1);
      @(posedge clk); #1;
      repeat (45) @(posedge clk);
      #1;
      do_div(0, 32'd100, 32'd7, 0, 0, 0, 64'h00000002_0000000E);

      // Randomized operands and handshake timing against the model
      for (int i = 0; i < 24; i++) begin
         u = i % 2;
         a = rand_operand();
         b = rand_operand();
         do_div(u, a, b, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), model(u, a, b));
      end

      repeat (5) @(posedge clk);
      #1;
      chk("outstanding_s", 64'(exp_q0.size()), 64'd0);
      chk("outstanding_u", 64'(exp_q1.size()), 64'd0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Iterative restoring radix-2 divider. It is the responder side of the divider stream interface that the execute stage drives for DIV/DIVU.
- Two operand channels (dividend, divisor) are accepted with valid/ready. One result beat is returned with no backpressure.
- One instance is built with SIGNED=1 for DIV and one with SIGNED=0 for DIVU. Both are drop-in replacements for the vendor divider IP.

Parameters:
- WIDTH, 32, operand width in bits.
- SIGNED, 1, 1 = two's-complement divide; 0 = unsigned divide.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s_axis_dividend_tvalid  in  1  dividend offered
- s_axis_dividend_tready  out  1  dividend accepted this cycle if valid
- s_axis_dividend_tdata  in  WIDTH  dividend
- s_axis_divisor_tvalid  in  1  divisor offered
- s_axis_divisor_tready  out  1  divisor accepted this cycle if valid
- s_axis_divisor_tdata  in  WIDTH  divisor
- m_axis_dout_tvalid  out  1  one-cycle result pulse
- m_axis_dout_tdata  out  2*WIDTH  {remainder[WIDTH-1:0] (HI), quotient[WIDTH-1:0] (LO)}

Behaviour:
- Clock/reset: clk; reset is synchronous, active-high.
- Reset state:
  - State = IDLE; both captured flags clear.
  - dout_tvalid = 0, dout_tdata = 0.
  - Both treadys are forced 0 while reset is high.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - Each channel's tready = 1 until that channel is captured. The flag is set and the data registered on tvalid && tready.
  - Channels are captured independently, in any order or in the same cycle.
  - A captured channel holds tready = 0 until return to IDLE.
  - Transition to CALC on the edge where the second operand is captured. Call that cycle T.
- CALC:
  - Runs exactly WIDTH cycles, T+1..T+WIDTH, with a down-counter from WIDTH-1 to 0.
  - Operates on magnitudes: |x| when SIGNED, else raw.
  - Each cycle: shift {rem, quo} left by 1, bringing in the next quotient bit. Trial subtract the divisor magnitude from the (WIDTH+1)-bit partial remainder. If non-negative, keep the difference and set the quotient LSB = 1; else restore and set it to 0.
  - Counter == 0 moves to FIX.
- FIX (cycle T+WIDTH+1):
  - If SIGNED and sign(dividend) != sign(divisor), negate the quotient.
  - If SIGNED and dividend negative, negate the remainder.
  - Unsigned: pass through.
- DONE (cycle T+WIDTH+2):
  - dout_tvalid = 1 for exactly one cycle; dout_tdata is valid that cycle.
  - Next state IDLE; flags clear; both treadys = 1 again the following cycle.
- Latency: 34 cycles (WIDTH=32) from the second-operand capture edge to the tvalid cycle. Throughput is one divide per 35 cycles.
- dout_tdata holds its last value after DONE; only the tvalid pulse qualifies it.
- Operands offered while not in IDLE (or after capture) are not accepted; the initiator holds them.
- Divide by zero:
  - No error signal.
  - Magnitude quotient = all ones; magnitude remainder = |dividend|. The FIX rules then apply.
  - Unsigned n/0 gives q = 0xFFFFFFFF, r = n.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0. This is the natural result of the magnitude path; no special case.
- Reset mid-operation (any state): abort immediately; no tvalid is produced for the aborted divide; captured operands are discarded.
- Internal magnitude math uses WIDTH bits unsigned; |0x80000000| = 0x80000000 is representable.

Decomposition:
- Shared package (divider_pkg): state encoding constants (IDLE/CALC/FIX/DONE) and the DIV_LATENCY constant (WIDTH+2), used by the stage-level stall logic and the bench.
- One natural sub-module: div_step. It is a combinational single restoring iteration: in (partial rem, quo, divisor mag), out (next rem, next quo).
- The FSM, counter, capture flags and sign fix stay in seq_divider.

Test Plan:
- SIGNED=1: dividend 7, divisor 2, both valid at cycle 0 -> tvalid only at cycle 34, tdata = 0x00000001_00000003.
- SIGNED=1: dividend 0xFFFFFFF9 (-7), divisor 2 -> tdata = 0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
- SIGNED=0:
  - 0xFFFFFFFF / 0x10 -> tdata = 0x0000000F_0FFFFFFF.
  - 5 / 0 -> tdata = 0x00000005_FFFFFFFF.
- Staggered operands: divisor valid at cycle 0, dividend valid at cycle 5 -> divisor_tready low from cycle 1, dividend_tready high until 5, tvalid at cycle 39. Operands offered again during CALC are not accepted until after DONE.
- Reset asserted at cycle 10 of a divide -> no tvalid ever for it, treadys = 1 after reset. A following 100/7 (SIGNED=1) returns 0x00000002_0000000E 34 cycles after its capture.
